sram_stream_reader: RTL and testbench
=====================================

# sram_stream_reader

Read-side master for the 8K x 32 simple dual-port SRAM macro. It accepts a (base address, length) command and issues sequential reads on the SRAM read port, accounting for the macro's one-cycle read latency. Returned words are emitted as a valid/ready stream through an internal FIFO, so downstream backpressure never drops data. It sits between the SRAM read port and compute/DMA consumers, alongside the existing write-path logic.

## Interface
- ADDR_W, 13, SRAM word-address width (2^ADDR_W words)
- DATA_W, 32, SRAM/stream data width
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_base  in  ADDR_W  first word address
- cmd_len  in  ADDR_W+1  word count, 0..2^ADDR_W
- sram_csbn  out  1  SRAM read enable, active low
- sram_raddr  out  ADDR_W  SRAM read address
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after csbn low
- m_valid  out  1  stream word available
- m_ready  in  1  consumer accepts word
- m_data  out  DATA_W  stream word
- m_last  out  1  marks final word of the command
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, RUN (issuing reads), DRAIN (all reads issued, FIFO emptying).
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch base into addr counter, len into remaining counter; len>0 -> RUN; len=0 -> pulse done next cycle, stay IDLE, no reads and no stream beats.
- RUN: issue a read (sram_csbn=0, sram_raddr=addr) when fifo_count + inflight < FIFO_DEPTH; inflight = 1 if a read was issued the previous cycle. Each issue: addr+1 modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0), remaining-1. Last issue -> DRAIN.
- The cycle after an issue, sram_rdata is written into the FIFO, tagged with last=1 if it was the final issued read.
- FIFO is show-ahead: m_valid = !empty; m_data/m_last from head; pop on m_valid&&m_ready. Push and pop in the same cycle are both honoured; count unchanged.
- DRAIN: no reads. When the last-tagged word is popped -> done=1 for one cycle, busy=0, state IDLE (cmd_ready=1) the same cycle done is high.
- sram_csbn=1 in all cycles where no read is issued; sram_raddr holds its last value (don't-care when csbn=1).
- The shared SRAM csbn also gates writes; the top level combines the writer's and this block's enables. This block only ever drives csbn low for reads.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

## Timing
- Reset values: state IDLE, cmd_ready=1, sram_csbn=1, sram_raddr=0, m_valid=0, m_last=0, m_data=0 (FIFO empty), busy=0, done=0.
- rst mid-command: aborts immediately, flushes FIFO and counters, discards in-flight read data, no done pulse.
- Command accepted in cycle T: busy=1 from T+1; first read issued in T+1; data in FIFO, m_valid=1 in T+3.
- With m_ready held high: one word per cycle; N words leave in T+3..T+N+2; done pulses in T+N+3.
- Backpressure: with m_ready low, at most FIFO_DEPTH reads outstanding or buffered; issue resumes the cycle after a pop frees a slot. Stream order always equals address order.
- m_data/m_valid/m_last hold stable while m_valid && !m_ready.

## Test plan
- Reset, then base=0x010, len=4, m_ready=1, SRAM preloaded mem[a]=a*3 -> raddr 0x010..0x013 in T+1..T+4; m_data 0x30,0x33,0x36,0x39 in T+3..T+6; m_last only on 0x39; done pulse T+7.
- base=0x1FFE, len=4 -> raddr sequence 0x1FFE,0x1FFF,0x0000,0x0001; data in the same order.
- len=16, m_ready toggling 1-of-3 cycles -> no lost/duplicated words; never more than 4 words buffered or in flight; csbn stalls while the FIFO is full.
- len=0 -> no csbn low, m_valid stays 0, done pulses at T+1; len=8192 from base 0 -> all 8192 words, single m_last.
- rst asserted while 5 of 10 words are delivered -> next cycle m_valid=0, csbn=1, cmd_ready=1, no done; a new command runs cleanly.
- cmd_valid held high across a command -> second command accepted only in the done cycle; back-to-back streams without gaps beyond the 3-cycle startup.

Source files
------------

// File: rtl/sram_stream_reader.sv
// Streaming read master for the 8K x 32 SRAM macro: turns a (base, length) command
// into sequential reads and emits the returned words through a show-ahead FIFO.
module sram_stream_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              sram_csbn,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // RUN   | issuing reads while the FIFO has room
    // DRAIN | all reads issued, waiting for the last word to leave
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] raddr_q;
    logic              inflight;
    logic              inflight_last;

    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occupancy;
    logic [DATA_W:0]   head;

    logic accept;
    logic issue;
    logic issue_last;
    logic push;
    logic pop;
    logic fifo_empty;

    assign cmd_ready  = (state == ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign busy       = (state != ST_IDLE);

    // A read issued last cycle already owns a FIFO slot even though its data has not landed.
    assign occupancy  = fifo_count + CNT_W'(inflight);
    assign issue      = (state == ST_RUN) && (occupancy < DEPTH_C);
    assign issue_last = issue && (remaining == LEN_ONE);

    assign sram_csbn  = !issue;
    assign sram_raddr = issue ? addr : raddr_q;

    assign push       = inflight;
    assign fifo_empty = (fifo_count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign m_valid    = !fifo_empty;
    assign m_data     = m_valid ? head[DATA_W-1:0] : '0;
    assign m_last     = m_valid && head[DATA_W];
    assign pop        = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            addr          <= '0;
            remaining     <= '0;
            raddr_q       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue_last;
            if (issue) begin
                raddr_q   <= addr;
                addr      <= addr + ADDR_ONE;
                remaining <= remaining - LEN_ONE;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr      <= cmd_base;
                        remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && m_last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; m_data is masked while the FIFO is empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {inflight_last, sram_rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: SRAM model, per-cycle reference model of the command
// stream (expected reads and beats as queues) and directed timing pins.
`timescale 1ns/1ps
module tb_sram_stream_reader;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              m_ready = 1'b0;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [ADDR_W:0]   cmd_len = '0;
    logic [DATA_W-1:0] sram_rdata = '0;
    logic              cmd_ready, sram_csbn, m_valid, m_last, busy, done;
    logic [ADDR_W-1:0] sram_raddr;
    logic [DATA_W-1:0] m_data;

    logic [DATA_W-1:0] mem [WORDS];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;

    // reference model state
    logic [DATA_W:0]   exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    bit busy_m = 0, done_due = 0, armed = 0, stall_prev = 0;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;
    int out_m = 0, max_out = 0;

    // event logs for directed timing checks
    int                iss_cyc [$];
    logic [ADDR_W-1:0] iss_addr [$];
    int                pop_cyc [$];
    logic [DATA_W-1:0] pop_data [$];
    bit                pop_last [$];
    int                done_cyc [$];

    sram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .sram_csbn(sram_csbn), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (sram_csbn === 1'b0) sram_rdata <= mem[sram_raddr];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (cyc % 3 == 0);
                2: m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : compare
        bit was_busy, done_next;
        logic [DATA_W:0] e;
        logic [ADDR_W-1:0] a;
        if (armed) begin
            was_busy  = busy_m;
            done_next = 0;
            chk("cmd_ready", cmd_ready, !busy_m);
            chk("busy", busy, busy_m);
            chk("done", done, done_due);
            if (done === 1'b1) done_cyc.push_back(cyc);
            if (sram_csbn === 1'b0) begin
                iss_cyc.push_back(cyc);
                iss_addr.push_back(sram_raddr);
                chk("read_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) chk("raddr", sram_raddr, addr_q.pop_front());
                out_m++;
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                pop_cyc.push_back(cyc);
                pop_data.push_back(m_data);
                pop_last.push_back(m_last);
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e[DATA_W-1:0]);
                    chk("m_last", m_last, e[DATA_W]);
                    if (e[DATA_W]) begin
                        busy_m    = 0;
                        done_next = 1;
                    end
                end
                out_m--;
            end
            if (out_m > max_out) max_out = out_m;
            chk("outstanding_le_depth", out_m <= DEPTH, 1);
            if (stall_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            stall_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
            prev_data  = m_data;
            prev_last  = m_last;
            if (cmd_valid && !was_busy) begin
                for (int i = 0; i < int'(cmd_len); i++) begin
                    a = cmd_base + ADDR_W'(i);
                    addr_q.push_back(a);
                    exp_q.push_back({i == int'(cmd_len) - 1, mem[a]});
                end
                if (cmd_len == '0) done_next = 1;
                else busy_m = 1;
            end
            done_due = done_next;
        end
        if (rst === 1'b1) begin
            exp_q.delete();
            addr_q.delete();
            busy_m = 0; done_due = 0; stall_prev = 0; out_m = 0;
            armed = 1;
        end
    end

    task automatic clear_logs();
        iss_cyc.delete(); iss_addr.delete();
        pop_cyc.delete(); pop_data.delete(); pop_last.delete();
        done_cyc.delete();
        max_out = 0;
    endtask

    task automatic send_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l, output int t);
        cmd_base = b; cmd_len = l; cmd_valid = 1'b1; t = -1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                t = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("cmd_accepted", t >= 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (!busy_m && !done_due && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("idle_within_budget", ok, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int t, t1, t2, n;
        logic [ADDR_W-1:0] t2a [4];
        t2a = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        for (int a = 0; a < WORDS; a++) mem[a] = DATA_W'(a * 3);

        // reset values
        mode = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_csbn", sram_csbn, 1);
        chk("rst_raddr", sram_raddr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;

        // base 0x010, len 4, m_ready high: exact cycle timing
        clear_logs();
        send_cmd(13'h010, 14'd4, t);
        wait_idle(100);
        chk("t1_issues", iss_cyc.size(), 4);
        chk("t1_beats", pop_cyc.size(), 4);
        for (int i = 0; i < 4 && i < iss_cyc.size(); i++) begin
            chk("t1_iss_cyc", iss_cyc[i], t + 1 + i);
            chk("t1_raddr", iss_addr[i], 13'h010 + i);
        end
        for (int i = 0; i < 4 && i < pop_cyc.size(); i++) begin
            chk("t1_pop_cyc", pop_cyc[i], t + 3 + i);
            chk("t1_data", pop_data[i], 32'h30 + 3 * i);
            chk("t1_last", pop_last[i], i == 3);
        end
        chk("t1_done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("t1_done_cyc", done_cyc[0], t + 7);

        // address wrap
        clear_logs();
        send_cmd(13'h1FFE, 14'd4, t);
        wait_idle(100);
        chk("t2_beats", pop_data.size(), 4);
        for (int i = 0; i < 4 && i < iss_addr.size(); i++) chk("t2_raddr", iss_addr[i], t2a[i]);
        for (int i = 0; i < 4 && i < pop_data.size(); i++) chk("t2_data", pop_data[i], 32'(t2a[i]) * 3);

        // backpressure 1-of-3
        clear_logs();
        mode = 1;
        send_cmd(13'h0400, 14'd16, t);
        wait_idle(400);
        chk("t3_beats", pop_data.size(), 16);
        chk("t3_max_outstanding", max_out, DEPTH);
        if (iss_cyc.size() == 16) chk("t3_issue_stalled", iss_cyc[15] - iss_cyc[0] > 15, 1);
        mode = 0;

        // len 0
        clear_logs();
        send_cmd(13'h0123, 14'd0, t);
        wait_idle(20);
        chk("t4_no_reads", iss_cyc.size(), 0);
        chk("t4_no_beats", pop_cyc.size(), 0);
        chk("t4_done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("t4_done_cyc", done_cyc[0], t + 1);

        // full memory sweep
        clear_logs();
        send_cmd(13'h0000, 14'd8192, t);
        wait_idle(9000);
        chk("t5_beats", pop_data.size(), 8192);
        n = 0;
        foreach (pop_last[i]) if (pop_last[i]) n++;
        chk("t5_single_last", n, 1);
        if (pop_last.size() == 8192) chk("t5_last_pos", pop_last[8191], 1);
        if (done_cyc.size() > 0) chk("t5_done_cyc", done_cyc[0], t + 8195);

        // reset mid-command
        clear_logs();
        send_cmd(13'h00A0, 14'd10, t);
        for (int i = 0; i < 100 && pop_cyc.size() < 5; i++) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_m_valid", m_valid, 0);
        chk("t6_csbn", sram_csbn, 1);
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_done", done, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_done", done_cyc.size(), 0);
        chk("t6_partial", (pop_cyc.size() >= 5) && (pop_cyc.size() < 10), 1);
        n = pop_cyc.size();
        send_cmd(13'h0200, 14'd6, t);
        wait_idle(100);
        chk("t6_after_beats", pop_cyc.size() - n, 6);
        chk("t6_after_done", done_cyc.size(), 1);

        // cmd_valid held high across two commands
        clear_logs();
        cmd_base = 13'h0100; cmd_len = 14'd6; cmd_valid = 1'b1;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin t1 = cyc; break; end
        end
        @(posedge clk); #1;
        cmd_base = 13'h0300; cmd_len = 14'd5;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin t2 = cyc; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle(100);
        chk("t7_second_at", t2, t1 + 9);
        if (done_cyc.size() > 0) chk("t7_done_first", done_cyc[0], t2);
        chk("t7_beats", pop_cyc.size(), 11);
        if (pop_cyc.size() == 11) chk("t7_second_start", pop_cyc[6], t2 + 3);

        // randomized commands and backpressure
        for (int a = 0; a < WORDS; a++) mem[a] = $urandom;
        mode = 2;
        for (int k = 0; k < 20; k++) begin
            clear_logs();
            n = $urandom_range(0, 40);
            send_cmd(ADDR_W'($urandom_range(0, WORDS - 1)), (ADDR_W + 1)'(n), t);
            wait_idle(500);
            chk("rand_beats", pop_cyc.size(), n);
            chk("rand_done", done_cyc.size(), 1);
        end
        mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
